// File: rtl/sync_detect.sv
// Sync pulse analyser: measures the period and active width of a sampled sync
// stream and reports lock once consecutive periods agree.
module sync_detect #(
    parameter bit POLARITY = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        update,
    input  logic        sync_in,
    output logic [15:0] count,
    output logic [15:0] period,
    output logic [15:0] pulse_width,
    output logic        sync_start,
    output logic        locked,
    output logic        timeout
);

    localparam int unsigned CW     = 16;
    localparam logic [CW-1:0] CMAX = '1;
    localparam logic INVERT        = (POLARITY == 1'b0);

    typedef enum logic [1:0] {
        SEARCH  = 2'd0,
        MEASURE = 2'd1,
        CHECK   = 2'd2,
        LOCKED  = 2'd3
    } state_t;

    state_t        state;
    state_t        state_nx;
    logic          prev;
    logic          s;
    logic          rise;
    logic          fall;
    logic          period_ld;
    logic          timeout_nx;
    logic [CW-1:0] count_inc;

    // Edge detection on the polarity-normalised sync, only on sample strobes
    assign s         = sync_in ^ INVERT;
    assign rise      = update & s & ~prev;
    assign fall      = update & ~s & prev;
    assign count_inc = (count == CMAX) ? CMAX : count + CW'(1);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= SEARCH;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx   = state;
        period_ld  = 1'b0;
        timeout_nx = 1'b0;
        if (rise) begin
            case (state)
                SEARCH: begin
                    state_nx = MEASURE;
                end
                MEASURE: begin
                    period_ld = 1'b1;
                    state_nx  = CHECK;
                end
                CHECK: begin
                    if (count_inc == period) begin
                        state_nx = LOCKED;
                    end else begin
                        period_ld = 1'b1;
                    end
                end
                LOCKED: begin
                    if (count_inc != period) begin
                        period_ld = 1'b1;
                        state_nx  = CHECK;
                    end
                end
                default: begin
                    state_nx = SEARCH;
                end
            endcase
        end else if (update && (count == CMAX) && (state != SEARCH)) begin
            // A rise on the saturating sample wins; otherwise the lock is lost
            state_nx   = SEARCH;
            timeout_nx = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count       <= '0;
            period      <= '0;
            pulse_width <= '0;
            sync_start  <= 1'b0;
            locked      <= 1'b0;
            timeout     <= 1'b0;
            prev        <= 1'b1;
        end else begin
            sync_start <= rise;
            timeout    <= timeout_nx;
            locked     <= (state_nx == LOCKED);
            if (update) begin
                prev  <= s;
                count <= rise ? '0 : count_inc;
                if (fall) begin
                    pulse_width <= count_inc;
                end
                if (period_ld) begin
                    period <= count_inc;
                end
            end
        end
    end

endmodule

// File: tb/tb_sync_detect.sv
// Randomised and directed bench for sync_detect, run on both polarities in
// parallel against a sample-index based reference model.
module tb_sync_detect;

    localparam int F_CNT = 0;
    localparam int F_PER = 1;
    localparam int F_PW  = 2;
    localparam int F_SS  = 3;
    localparam int F_LK  = 4;
    localparam int F_TO  = 5;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        update = 1'b0;
    logic        act = 1'b0;
    logic        sync_p;
    logic        sync_n;
    logic [15:0] count_p, period_p, pulse_width_p;
    logic [15:0] count_n, period_n, pulse_width_n;
    logic        sync_start_p, locked_p, timeout_p;
    logic        sync_start_n, locked_n, timeout_n;

    int errors = 0;
    int checks = 0;

    // Reference model: sample indices of the origin (reset or last rise)
    int          m_n, m_org, m_rises, m_last_iv;
    logic        m_prev, m_start, m_locked, m_tmo;
    logic [15:0] m_period, m_pw;

    assign sync_p = act;
    assign sync_n = ~act;

    always #5 clk = ~clk;

    sync_detect #(.POLARITY(1'b1)) dut_p (
        .clk(clk), .rst(rst), .update(update), .sync_in(sync_p),
        .count(count_p), .period(period_p), .pulse_width(pulse_width_p),
        .sync_start(sync_start_p), .locked(locked_p), .timeout(timeout_p)
    );

    sync_detect #(.POLARITY(1'b0)) dut_n (
        .clk(clk), .rst(rst), .update(update), .sync_in(sync_n),
        .count(count_n), .period(period_n), .pulse_width(pulse_width_n),
        .sync_start(sync_start_n), .locked(locked_n), .timeout(timeout_n)
    );

    function automatic logic [15:0] sat16(input int v);
        return (v > 65535) ? 16'hFFFF : 16'(v);
    endfunction

    task automatic check_eq(input string tag, input logic [15:0] got, input logic [15:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [15:0] field(input int sel, input bit neg);
        case (sel)
            F_CNT:   return neg ? count_n : count_p;
            F_PER:   return neg ? period_n : period_p;
            F_PW:    return neg ? pulse_width_n : pulse_width_p;
            F_SS:    return 16'(neg ? sync_start_n : sync_start_p);
            F_LK:    return 16'(neg ? locked_n : locked_p);
            default: return 16'(neg ? timeout_n : timeout_p);
        endcase
    endfunction

    task automatic expect_both(input string tag, input int sel, input logic [15:0] exp);
        check_eq({tag, "_p"}, field(sel, 1'b0), exp);
        check_eq({tag, "_n"}, field(sel, 1'b1), exp);
    endtask

    task automatic model_step(input logic r, input logic u, input logic a);
        int age;
        logic [15:0] iv;
        if (r) begin
            m_n = 0; m_org = 0; m_rises = 0; m_last_iv = -1;
            m_prev = 1'b1; m_period = '0; m_pw = '0;
            m_start = 1'b0; m_locked = 1'b0; m_tmo = 1'b0;
        end else begin
            m_start = 1'b0;
            m_tmo   = 1'b0;
            if (u) begin
                age = m_n - m_org;
                m_n++;
                if (a && !m_prev) begin
                    iv = sat16(m_n - m_org);
                    m_rises++;
                    // Locked exactly when the two latest intervals agree
                    if (m_rises >= 2) begin
                        m_locked  = (m_rises >= 3) && (int'(iv) == m_last_iv);
                        m_last_iv = int'(iv);
                        m_period  = iv;
                    end
                    m_org   = m_n;
                    m_start = 1'b1;
                end else begin
                    if (!a && m_prev) m_pw = sat16(m_n - m_org);
                    if (age >= 65535 && m_rises > 0) begin
                        m_tmo = 1'b1; m_rises = 0; m_locked = 1'b0;
                    end
                end
                m_prev = a;
            end
        end
    endtask

    task automatic check_all();
        for (int d = 0; d < 2; d++) begin
            string sfx;
            sfx = (d == 0) ? "_p" : "_n";
            check_eq({"count", sfx},  field(F_CNT, d[0]), sat16(m_n - m_org));
            check_eq({"period", sfx}, field(F_PER, d[0]), m_period);
            check_eq({"pw", sfx},     field(F_PW, d[0]),  m_pw);
            check_eq({"start", sfx},  field(F_SS, d[0]),  16'(m_start));
            check_eq({"locked", sfx}, field(F_LK, d[0]),  16'(m_locked));
            check_eq({"tmo", sfx},    field(F_TO, d[0]),  16'(m_tmo));
        end
    endtask

    task automatic step(input logic r, input logic u, input logic a);
        rst = r; update = u; act = a;
        @(posedge clk);
        model_step(r, u, a);
        #1;
        check_all();
    endtask

    // n samples at level a; div>1 inserts idle cycles with random sync_in
    task automatic emit(input logic a, input int n, input int div);
        for (int i = 0; i < n; i++) begin
            for (int k = 1; k < div; k++) step(1'b0, 1'b0, 1'($urandom_range(0, 1)));
            step(1'b0, 1'b1, a);
        end
    endtask

    task automatic line(input int front, input int width, input int back, input int div);
        emit(1'b0, front, div);
        emit(1'b1, width, div);
        emit(1'b0, back, div);
    endtask

    task automatic do_reset(input logic a);
        step(1'b1, 1'b1, a);
        step(1'b1, 1'b0, a);
    endtask

    initial begin
        // Reset state
        do_reset(1'b0);
        expect_both("rst_count", F_CNT, 16'd0);
        expect_both("rst_period", F_PER, 16'd0);
        expect_both("rst_pw", F_PW, 16'd0);
        expect_both("rst_locked", F_LK, 16'd0);
        expect_both("rst_tmo", F_TO, 16'd0);

        // SVGA horizontal, full rate
        line(840, 128, 88, 1);
        line(840, 128, 88, 1);
        emit(1'b0, 840, 1);
        emit(1'b1, 1, 1);
        expect_both("svga_count", F_CNT, 16'd0);
        expect_both("svga_start", F_SS, 16'd1);
        expect_both("svga_period", F_PER, 16'd1056);
        expect_both("svga_locked", F_LK, 16'd1);
        emit(1'b1, 127, 1);
        emit(1'b0, 88, 1);
        expect_both("svga_pw", F_PW, 16'd128);

        // One lengthened line breaks lock; a second one restores it
        emit(1'b0, 844, 1);
        emit(1'b1, 1, 1);
        expect_both("long_period", F_PER, 16'd1060);
        expect_both("long_unlock", F_LK, 16'd0);
        emit(1'b1, 127, 1);
        emit(1'b0, 88, 1);
        emit(1'b0, 844, 1);
        emit(1'b1, 1, 1);
        expect_both("long_relock", F_LK, 16'd1);

        // Reset while locked with sync active at release
        emit(1'b1, 50, 1);
        do_reset(1'b1);
        expect_both("lrst_count", F_CNT, 16'd0);
        expect_both("lrst_period", F_PER, 16'd0);
        expect_both("lrst_locked", F_LK, 16'd0);
        emit(1'b1, 30, 1);
        expect_both("lrst_nostart", F_SS, 16'd0);
        expect_both("lrst_count30", F_CNT, 16'd30);
        emit(1'b0, 5, 1);
        emit(1'b1, 1, 1);
        expect_both("lrst_start", F_SS, 16'd1);
        emit(1'b1, 9, 1);
        emit(1'b0, 90, 1);
        emit(1'b1, 1, 1);
        expect_both("lrst_rise2", F_LK, 16'd0);
        emit(1'b1, 9, 1);
        emit(1'b0, 90, 1);
        emit(1'b1, 1, 1);
        expect_both("lrst_rise3", F_LK, 16'd1);
        expect_both("lrst_period100", F_PER, 16'd100);

        // Sync stuck active after lock
        emit(1'b1, 65535, 1);
        expect_both("stuck_sat", F_CNT, 16'hFFFF);
        expect_both("stuck_pre_tmo", F_TO, 16'd0);
        emit(1'b1, 1, 1);
        expect_both("stuck_tmo", F_TO, 16'd1);
        expect_both("stuck_unlock", F_LK, 16'd0);
        expect_both("stuck_hold", F_CNT, 16'hFFFF);
        emit(1'b1, 1, 1);
        expect_both("stuck_tmo_once", F_TO, 16'd0);
        emit(1'b0, 3, 1);
        emit(1'b1, 1, 1);
        expect_both("search_keep_per", F_PER, 16'd100);

        // SVGA at half update rate
        do_reset(1'b0);
        line(840, 128, 88, 2);
        line(840, 128, 88, 2);
        emit(1'b0, 840, 2);
        emit(1'b1, 1, 2);
        expect_both("half_period", F_PER, 16'd1056);
        expect_both("half_locked", F_LK, 16'd1);
        step(1'b0, 1'b0, 1'($urandom_range(0, 1)));
        expect_both("half_idle_start", F_SS, 16'd0);
        expect_both("half_idle_count", F_CNT, 16'd0);
        emit(1'b1, 127, 2);
        emit(1'b0, 88, 2);
        expect_both("half_pw", F_PW, 16'd128);

        // 100-sample period, 10-sample active pulse
        do_reset(1'b0);
        for (int l = 0; l < 2; l++) line(90, 10, 0, 1);
        emit(1'b0, 90, 1);
        emit(1'b1, 1, 1);
        expect_both("p100_period", F_PER, 16'd100);
        expect_both("p100_locked", F_LK, 16'd1);
        expect_both("p100_pw", F_PW, 16'd10);

        // Random periodic streams with jitter, idle cycles and resets
        do_reset(1'b0);
        for (int seg = 0; seg < 12; seg++) begin
            int p, w, nl, g, pl;
            p  = int'($urandom_range(12, 50));
            w  = int'($urandom_range(1, p - 1));
            nl = int'($urandom_range(2, 5));
            g  = int'($urandom_range(0, 3));
            for (int l = 0; l < nl; l++) begin
                pl = p + (($urandom_range(0, 5) == 0) ? 1 : 0);
                for (int i = 0; i < pl; i++) begin
                    if (int'($urandom_range(0, 3)) < g) step(1'b0, 1'b0, 1'($urandom_range(0, 1)));
                    if ($urandom_range(0, 499) == 0) step(1'b1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
                    step(1'b0, 1'b1, i >= pl - w);
                end
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
